// File: rtl/fpu_arbiter_if.sv
// Requester/fpu bundle for fpu_arbiter.
//   master : arbiter view. Takes the packed requester orders/operands and the fpu
//            handshake; drives per-requester accepted/done, the shared result bus
//            and the fpu order/operand lines.
//   slave  : environment view (requesters plus fpu), the mirror of master.
interface fpu_arbiter_if #(
    parameter int N_REQ    = 2,
    parameter int LEN_WORD = 32
);
    logic [N_REQ-1:0]          req_order;
    logic [N_REQ*3-1:0]        req_func3;
    logic [N_REQ*7-1:0]        req_func7;
    logic [N_REQ*LEN_WORD-1:0] req_rs1;
    logic [N_REQ*LEN_WORD-1:0] req_rs2;
    logic [N_REQ-1:0]          req_accepted;
    logic [N_REQ-1:0]          req_done;
    logic [LEN_WORD-1:0]       req_rd;

    logic                      fpu_order;
    logic [2:0]                fpu_func3;
    logic [6:0]                fpu_func7;
    logic [LEN_WORD-1:0]       fpu_rs1;
    logic [LEN_WORD-1:0]       fpu_rs2;
    logic                      fpu_accepted;
    logic                      fpu_done;
    logic [LEN_WORD-1:0]       fpu_rd;

    modport master (
        input  req_order, req_func3, req_func7, req_rs1, req_rs2,
        input  fpu_accepted, fpu_done, fpu_rd,
        output req_accepted, req_done, req_rd,
        output fpu_order, fpu_func3, fpu_func7, fpu_rs1, fpu_rs2
    );

    modport slave (
        output req_order, req_func3, req_func7, req_rs1, req_rs2,
        output fpu_accepted, fpu_done, fpu_rd,
        input  req_accepted, req_done, req_rd,
        input  fpu_order, fpu_func3, fpu_func7, fpu_rs1, fpu_rs2
    );
endinterface

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin share of one fpu between N_REQ requesters.
// One operation in flight at a time; the winner's operands are latched at grant,
// the fpu order is sequenced, and rd/done are routed back to the winner only.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous reset, active-high
//   bus  : fpu_arbiter_if.master (requester orders/operands in, accepted/done/rd out;
//          fpu order/operands out, fpu accepted/done/rd in)

// Per-requester slice: eligibility and packed operand word.
module fpu_arbiter_lane #(
    parameter int LEN_WORD = 32,
    parameter int OPW      = 10 + 2*LEN_WORD
) (
    input  logic                order,
    input  logic                done,
    input  logic [2:0]          func3,
    input  logic [6:0]          func7,
    input  logic [LEN_WORD-1:0] rs1,
    input  logic [LEN_WORD-1:0] rs2,
    output logic                elig,
    output logic [OPW-1:0]      op
);
    // A requester being told done this cycle still shows its old order; masking
    // it here keeps that stale order from winning a second grant.
    assign elig = order & ~done;
    assign op   = {func3, func7, rs1, rs2};
endmodule

module fpu_arbiter #(
    parameter int N_REQ    = 2,
    parameter int LEN_WORD = 32
) (
    input  logic           clk,
    input  logic           rst,
    fpu_arbiter_if.master  bus
);
    localparam int GW  = $clog2(N_REQ);
    localparam int OPW = 10 + 2*LEN_WORD;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    typedef struct packed {
        logic [2:0]          func3;
        logic [6:0]          func7;
        logic [LEN_WORD-1:0] rs1;
        logic [LEN_WORD-1:0] rs2;
    } op_t;

    state_t              state, state_nxt;
    logic [GW-1:0]       rr_ptr, grant, winner;
    logic                any_elig;
    logic [N_REQ-1:0]    elig;
    logic [OPW-1:0]      lane_op [N_REQ];
    op_t                 op_q;
    logic [N_REQ-1:0]    acc_q, done_q;
    logic [LEN_WORD-1:0] rd_q;
    logic                order;
    logic                finish;
    logic [N_REQ-1:0]    win_oh, grant_oh;

    genvar g;
    generate
        for (g = 0; g < N_REQ; g++) begin : g_lane
            fpu_arbiter_lane #(.LEN_WORD(LEN_WORD), .OPW(OPW)) u_lane (
                .order (bus.req_order[g]),
                .done  (done_q[g]),
                .func3 (bus.req_func3[g*3 +: 3]),
                .func7 (bus.req_func7[g*7 +: 7]),
                .rs1   (bus.req_rs1[g*LEN_WORD +: LEN_WORD]),
                .rs2   (bus.req_rs2[g*LEN_WORD +: LEN_WORD]),
                .elig  (elig[g]),
                .op    (lane_op[g])
            );
        end
    endgenerate

    // First eligible index scanning rr_ptr, rr_ptr+1, ... with wrap at N_REQ
    // (explicit subtract so non-power-of-2 N_REQ wraps correctly).
    always_comb begin
        int idx;
        idx      = 0;
        winner   = '0;
        any_elig = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!any_elig && elig[idx]) begin
                winner   = GW'(idx);
                any_elig = 1'b1;
            end
        end
    end

    assign win_oh   = {{(N_REQ-1){1'b0}}, 1'b1} << winner;
    assign grant_oh = {{(N_REQ-1){1'b0}}, 1'b1} << grant;

    // Next state and fpu-side strobes.
    always_comb begin
        state_nxt = state;
        order     = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                // stray fpu_done / fpu_accepted are ignored here
                if (any_elig) state_nxt = ISSUE;
            end
            ISSUE: begin
                order = 1'b1;
                if (bus.fpu_accepted) begin
                    if (bus.fpu_done) begin
                        finish    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.fpu_done) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            grant  <= '0;
            op_q   <= '0;
            acc_q  <= '0;
            done_q <= '0;
            rd_q   <= '0;
        end else begin
            state  <= state_nxt;
            acc_q  <= '0;
            done_q <= '0;
            if (state == IDLE && any_elig) begin
                grant  <= winner;
                op_q   <= op_t'(lane_op[winner]);
                rr_ptr <= (winner == GW'(N_REQ-1)) ? '0 : winner + GW'(1);
                acc_q  <= win_oh;
            end
            if (finish) begin
                rd_q   <= bus.fpu_rd;
                done_q <= grant_oh;
            end
        end
    end

    // fpu_order is a decode of ISSUE; after a completion the state is IDLE, so the
    // order is never held into the cycle following fpu_done.
    assign bus.fpu_order    = order;
    assign bus.fpu_func3    = op_q.func3;
    assign bus.fpu_func7    = op_q.func7;
    assign bus.fpu_rs1      = op_q.rs1;
    assign bus.fpu_rs2      = op_q.rs2;
    assign bus.req_accepted = acc_q;
    assign bus.req_done     = done_q;
    assign bus.req_rd       = rd_q;
endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter: reset, single-cycle op, alternating multi-cycle
// ops, accept stall, reset in WAIT, and operand/order changes after grant.
module tb_fpu_arbiter;
    localparam int N_REQ = 2;
    localparam int LW    = 32;
    localparam logic [6:0] FUNC7_FMVI = 7'b1111000;
    localparam logic [6:0] FUNC7_FDIV = 7'b0001100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fpu_arbiter_if #(.N_REQ(N_REQ), .LEN_WORD(LW)) bus ();

    fpu_arbiter #(.N_REQ(N_REQ), .LEN_WORD(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [LW-1:0] a, input logic [LW-1:0] b);
        bus.req_func3[i*3 +: 3]   = f3;
        bus.req_func7[i*7 +: 7]   = f7;
        bus.req_rs1[i*LW +: LW]   = a;
        bus.req_rs2[i*LW +: LW]   = b;
    endtask

    // Entered right after the grant edge (ISSUE cycle). Stalls accept for 'stall'
    // cycles, completes 'lat' cycles after accept (0 = same cycle), and leaves the
    // bench sampling the req_done cycle.
    task automatic run_op(input int g, input int stall, input int lat,
                          input logic [LW-1:0] rs1, input logic [LW-1:0] rd);
        logic [N_REQ-1:0] oh;
        oh = N_REQ'(1 << g);
        chk("acc", bus.req_accepted, oh);
        chk("order", bus.fpu_order, 1);
        chk("rs1", bus.fpu_rs1, rs1);
        chk("done_idle", bus.req_done, 0);
        for (int s = 0; s < stall; s++) begin
            step();
            chk("stall_order", bus.fpu_order, 1);
            chk("stall_acc", bus.req_accepted, 0);
            chk("stall_rs1", bus.fpu_rs1, rs1);
        end
        bus.fpu_accepted = 1'b1;
        bus.fpu_done     = (lat == 0);
        if (lat == 0) bus.fpu_rd = rd;
        step();
        bus.fpu_accepted = 1'b0;
        if (lat > 0) begin
            for (int i = 1; i < lat; i++) begin
                chk("wait_order", bus.fpu_order, 0);
                chk("wait_done", bus.req_done, 0);
                step();
            end
            chk("wait_order", bus.fpu_order, 0);
            bus.fpu_done = 1'b1;
            bus.fpu_rd   = rd;
            step();
        end
        bus.fpu_done = 1'b0;
        chk("done", bus.req_done, oh);
        chk("rd", bus.req_rd, rd);
        chk("post_order", bus.fpu_order, 0);
    endtask

    initial begin
        bus.req_order    = '0;
        bus.req_func3    = '0;
        bus.req_func7    = '0;
        bus.req_rs1      = '0;
        bus.req_rs2      = '0;
        bus.fpu_accepted = 1'b0;
        bus.fpu_done     = 1'b0;
        bus.fpu_rd       = '0;

        // 1: reset with both orders up; first grant goes to requester 0
        set_op(0, 3'd0, FUNC7_FMVI, 32'h1111_0000, 32'h0);
        set_op(1, 3'd0, FUNC7_FMVI, 32'h2222_0000, 32'h0);
        bus.req_order = 2'b11;
        rst = 1'b1;
        step();
        step();
        chk("rst_order", bus.fpu_order, 0);
        chk("rst_acc", bus.req_accepted, 0);
        chk("rst_done", bus.req_done, 0);
        chk("rst_rd", bus.req_rd, 0);
        chk("rst_f3", bus.fpu_func3, 0);
        chk("rst_f7", bus.fpu_func7, 0);
        chk("rst_rs1", bus.fpu_rs1, 0);
        chk("rst_rs2", bus.fpu_rs2, 0);
        rst = 1'b0;
        step();
        run_op(0, 0, 0, 32'h1111_0000, 32'hAAAA_0001);
        bus.req_order = 2'b00;
        step();
        chk("t1_idle_acc", bus.req_accepted, 0);

        // 2: single fmv from requester 1
        set_op(1, 3'd0, FUNC7_FMVI, 32'h3F80_0000, 32'h0);
        bus.req_order = 2'b10;
        step();
        chk("t2_f7", bus.fpu_func7, FUNC7_FMVI);
        run_op(1, 0, 0, 32'h3F80_0000, 32'h3F80_0000);
        bus.req_order = 2'b00;
        step();
        chk("t2_done_once", bus.req_done, 0);

        // 3: both hold order, fdiv done 10 cycles after accept -> 0,1,0,1
        set_op(0, 3'd0, FUNC7_FDIV, 32'h4000_0000, 32'h3F80_0000);
        set_op(1, 3'd0, FUNC7_FDIV, 32'h4040_0000, 32'h3F80_0000);
        bus.req_order = 2'b11;
        step();
        run_op(0, 0, 10, 32'h4000_0000, 32'hD000_0000);
        step();
        run_op(1, 0, 10, 32'h4040_0000, 32'hD000_0001);
        step();
        run_op(0, 0, 10, 32'h4000_0000, 32'hD000_0002);
        step();
        run_op(1, 0, 10, 32'h4040_0000, 32'hD000_0003);
        bus.req_order = 2'b00;
        step();
        chk("t3_done_once", bus.req_done, 0);
        chk("t3_no_regrant", bus.fpu_order, 0);

        // 4: fpu holds accepted low for 3 cycles
        set_op(0, 3'd1, FUNC7_FDIV, 32'h5555_0000, 32'h6666_0000);
        bus.req_order = 2'b01;
        step();
        run_op(0, 3, 0, 32'h5555_0000, 32'hBEEF_0004);
        bus.req_order = 2'b00;
        step();

        // 5: reset while in WAIT; later stray fpu_done ignored
        set_op(1, 3'd0, FUNC7_FDIV, 32'h7777_0000, 32'h0);
        bus.req_order = 2'b10;
        step();
        chk("t5_acc", bus.req_accepted, 2'b10);
        bus.fpu_accepted = 1'b1;
        step();
        bus.fpu_accepted = 1'b0;
        chk("t5_wait_order", bus.fpu_order, 0);
        rst = 1'b1;
        bus.req_order = 2'b00;
        step();
        rst = 1'b0;
        chk("t5_rst_done", bus.req_done, 0);
        chk("t5_rst_order", bus.fpu_order, 0);
        chk("t5_rst_rs1", bus.fpu_rs1, 0);
        chk("t5_rst_rd", bus.req_rd, 0);
        step();
        bus.fpu_done = 1'b1;
        bus.fpu_rd   = 32'hDEAD_BEEF;
        step();
        bus.fpu_done = 1'b0;
        chk("t5_stray_done", bus.req_done, 0);
        chk("t5_stray_rd", bus.req_rd, 0);
        step();
        chk("t5_stray_done2", bus.req_done, 0);
        chk("t5_stray_order", bus.fpu_order, 0);

        // 6: requester 0 drops order and changes rs1 after accept
        set_op(0, 3'd2, FUNC7_FDIV, 32'hA0A0_A0A0, 32'h0B0B_0B0B);
        bus.req_order = 2'b01;
        step();
        chk("t6_acc", bus.req_accepted, 2'b01);
        chk("t6_rs1", bus.fpu_rs1, 32'hA0A0_A0A0);
        bus.fpu_accepted = 1'b1;
        step();
        bus.fpu_accepted = 1'b0;
        bus.req_order = 2'b00;
        bus.req_rs1[0 +: LW] = 32'hFFFF_0000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_hold_rs1", bus.fpu_rs1, 32'hA0A0_A0A0);
            chk("t6_hold_f3", bus.fpu_func3, 3'd2);
            chk("t6_order", bus.fpu_order, 0);
        end
        bus.fpu_done = 1'b1;
        bus.fpu_rd   = 32'h1234_5678;
        step();
        bus.fpu_done = 1'b0;
        chk("t6_done", bus.req_done, 2'b01);
        chk("t6_rd", bus.req_rd, 32'h1234_5678);
        step();
        chk("t6_no_regrant", bus.req_accepted, 0);
        chk("t6_rd_hold", bus.req_rd, 32'h1234_5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
